// File: rtl/mixcolumns_pipe.sv
// mixcolumns_pipe: handshaked AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns of the 128-bit state per clock.
// A bypass path forwards the state unchanged for the final round.
module mixcolumns_pipe #(
  parameter int unsigned COLS_PER_CYCLE = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] text_i,
  input  logic         mode_i,
  input  logic         bypass_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] text_o,
  output logic         busy_o
);

  // Only divisors of four give an integral number of column groups.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_pipe: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step and the counter value of the final column group.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Working state as four 32-bit columns; index 0 is the most significant
  // word, so the packed vector has exactly the text_i/text_o byte order.
  logic [0:3][31:0] st;
  logic [0:3][31:0] st_mixed;
  logic             mode;
  logic [1:0]       cnt;
  logic             accept;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by a constant 4-bit coefficient as an XOR of b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  // One column through the forward or inverse MixColumns matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (!inv) begin
      r0 = gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3;
      r1 = a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3;
      r2 = a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3);
      r3 = gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2);
    end else begin
      r0 = gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9);
      r1 = gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD);
      r2 = gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB);
      r3 = gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE);
    end
    return {r0, r1, r2, r3};
  endfunction

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; DONE may hand off straight into a new job.
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    busy_o     = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_next = bypass_i ? DONE : BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (cnt == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) begin
          if (valid_i) begin
            state_next = bypass_i ? DONE : BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    accept = valid_i && ready_o;
  end

  // Transform the current column group; other columns pass through.
  always_comb begin
    st_mixed = st;
    for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
      st_mixed[cnt + 2'(j)] = mix_col(st[cnt + 2'(j)], mode);
    end
  end

  // Working register, latched mode and column counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st   <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      st   <= text_i;
      mode <= mode_i;
      cnt  <= '0;
    end else if (state == BUSY) begin
      st  <= st_mixed;
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_STEP;
    end
  end

  assign text_o = st;

endmodule

// File: tb/tb_mixcolumns_pipe.sv
// Bench for mixcolumns_pipe: one instance per legal COLS_PER_CYCLE,
// fixed vectors plus random states checked against a GF(2^8) matrix model.
module tb_mixcolumns_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i  [3];
  logic         ready_o  [3];
  logic [127:0] text_i   [3];
  logic         mode_i   [3];
  logic         bypass_i [3];
  logic         valid_o  [3];
  logic         ready_i  [3];
  logic [127:0] text_o   [3];
  logic         busy_o   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mixcolumns_pipe #(.COLS_PER_CYCLE(C)) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (valid_i[g]),
      .ready_o  (ready_o[g]),
      .text_i   (text_i[g]),
      .mode_i   (mode_i[g]),
      .bypass_i (bypass_i[g]),
      .valid_o  (valid_o[g]),
      .ready_i  (ready_i[g]),
      .text_o   (text_o[g]),
      .busy_o   (busy_o[g])
    );
  end

  function automatic int cols_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Generic shift-and-add GF(2^8) product modulo 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  // Matrix-times-column on every column; row r uses the base row rotated right r times.
  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic inv, input logic byp);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (byp) return s;
    if (inv) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gf_mul(s[127-32*c-8*i -: 8], base[(i - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer a state at a negedge and let it be accepted at the next rising edge.
  task automatic start(input int k, input logic [127:0] txt, input logic m, input logic b, input string tag);
    valid_i[k]  = 1'b1;
    text_i[k]   = txt;
    mode_i[k]   = m;
    bypass_i[k] = b;
    #1;
    check({tag, " ready_o at offer"}, 128'(ready_o[k]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    valid_i[k]  = 1'b0;
    ready_i[k]  = 1'b0;
    text_i[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    mode_i[k]   = ~m;
    bypass_i[k] = 1'($urandom_range(0, 1));
  endtask

  // Count edges after acceptance until valid_o, scrambling ignored inputs meanwhile.
  task automatic wait_done(input int k, input logic [127:0] exp_text, input int exp_lat, input string tag);
    int n = 0;
    while (!valid_o[k] && n < 40) begin
      text_i[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mode_i[k] = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(exp_lat));
    check({tag, " text_o"}, text_o[k], exp_text);
    check({tag, " busy_o"}, 128'(busy_o[k]), 128'(1));
  endtask

  task automatic release_out(input int k, input string tag);
    ready_i[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i[k] = 1'b0;
    check({tag, " valid_o after handshake"}, 128'(valid_o[k]), 128'(0));
    check({tag, " ready_o after handshake"}, 128'(ready_o[k]), 128'(1));
  endtask

  function automatic int lat_of(input int k, input logic b);
    return b ? 0 : 4 / cols_of(k);
  endfunction

  task automatic txn(input int k, input logic [127:0] txt, input logic m, input logic b,
                     input logic [127:0] exp, input string tag);
    start(k, txt, m, b, tag);
    wait_done(k, exp, lat_of(k, b), tag);
    release_out(k, tag);
  endtask

  localparam logic [31:0] FWD_IN  [5] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5, 32'h2d26314c};
  localparam logic [31:0] FWD_OUT [5] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6, 32'h4d7ebdf8};
  localparam logic [127:0] FULL_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FULL_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] a, b;
    logic         m, byp;
    int           k;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i[i] = 1'b0; text_i[i] = '0; mode_i[i] = 1'b0;
      bypass_i[i] = 1'b0; ready_i[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset valid_o[%0d]", i), 128'(valid_o[i]), 128'(0));
      check($sformatf("reset ready_o[%0d]", i), 128'(ready_o[i]), 128'(1));
      check($sformatf("reset busy_o[%0d]", i),  128'(busy_o[i]),  128'(0));
      check($sformatf("reset text_o[%0d]", i),  text_o[i], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single-column vectors replicated across the state, four columns per cycle.
    for (int v = 0; v < 5; v++)
      txn(2, {4{FWD_IN[v]}}, 1'b0, 1'b0, {4{FWD_OUT[v]}}, $sformatf("fwd col vec%0d", v));

    // Full state forward on every width, then inverse.
    for (int i = 0; i < 3; i++) begin
      txn(i, FULL_IN,  1'b0, 1'b0, FULL_OUT, $sformatf("full fwd k%0d", i));
      txn(i, FULL_OUT, 1'b1, 1'b0, FULL_IN,  $sformatf("full inv k%0d", i));
    end
    txn(2, {4{32'h8e4da1bc}}, 1'b1, 1'b0, {4{32'hdb135345}}, "inv col vec");

    // Bypass on each width.
    for (int i = 0; i < 3; i++) begin
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      txn(i, a, 1'($urandom_range(0, 1)), 1'b1, a, $sformatf("bypass k%0d", i));
    end

    // Backpressure: DONE held for ten cycles with ready_i low.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = ref_model(a, 1'b0, 1'b0);
    start(1, a, 1'b0, 1'b0, "backpressure");
    wait_done(1, b, 2, "backpressure");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("backpressure valid_o", 128'(valid_o[1]), 128'(1));
      check("backpressure text_o",  text_o[1], b);
      check("backpressure ready_o", 128'(ready_o[1]), 128'(0));
    end
    release_out(1, "backpressure");

    // Back-to-back: result taken and next state accepted on the same edge.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    start(0, a, 1'b0, 1'b0, "b2b first");
    wait_done(0, ref_model(a, 1'b0, 1'b0), 4, "b2b first");
    ready_i[0] = 1'b1;
    start(0, b, 1'b1, 1'b0, "b2b second");
    wait_done(0, ref_model(b, 1'b1, 1'b0), 4, "b2b second");
    release_out(0, "b2b second");

    start(2, a, 1'b0, 1'b1, "b2b bypass first");
    wait_done(2, a, 0, "b2b bypass first");
    ready_i[2] = 1'b1;
    start(2, b, 1'b0, 1'b1, "b2b bypass second");
    wait_done(2, b, 0, "b2b bypass second");
    release_out(2, "b2b bypass second");

    // Random states, modes and widths.
    for (int it = 0; it < 30; it++) begin
      k   = int'($urandom_range(0, 2));
      a   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = 1'($urandom_range(0, 1));
      byp = ($urandom_range(0, 3) == 0);
      txn(k, a, m, byp, ref_model(a, m, byp), $sformatf("rand%0d k%0d m%0d b%0d", it, k, m, byp));
    end

    // Reset two edges into a one-column-per-cycle job.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    start(0, a, 1'b0, 1'b0, "midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset valid_o", 128'(valid_o[0]), 128'(0));
    check("midreset text_o",  text_o[0], '0);
    check("midreset ready_o", 128'(ready_o[0]), 128'(1));
    check("midreset busy_o",  128'(busy_o[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, FULL_IN, 1'b0, 1'b0, FULL_OUT, "after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
